// File: rtl/wb_pkg_hdl.sv
// Shared types for the Wibhbone memory responder: FSM states, termination status
// and the wait-state counter width.
package wb_pkg_hdl;

   localparam int unsigned WB_RESP_CNT_W = 4;

   typedef enum logic [1:0] {
      WB_RESP_IDLE,
      WB_RESP_WAIT,
      WB_RESP_TERM
   } wb_resp_state_t;

   typedef enum logic [1:0] {
      WB_RESP_OK,
      WB_RESP_ERR,
      WB_RESP_RTY
   } wb_resp_status_t;

   // Busy outranks a bad address: a busy slave retries without decoding.
   function automatic wb_resp_status_t wb_resp_classify(input logic busy,
                                                         input logic in_range);
      if (busy) begin
         return WB_RESP_RTY;
      end
      if (!in_range) begin
         return WB_RESP_ERR;
      end
      return WB_RESP_OK;
   endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone classic-cycle bus bundle between an initiator and a slave.
interface wb_if #(
   parameter int unsigned WB_ADDR_WIDTH = 32,
   parameter int unsigned WB_DATA_WIDTH = 16
);

   localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;

   logic                     cyc;
   logic                     stb;
   logic [WB_ADDR_WIDTH-1:0] adr;
   logic                     we;
   logic [SEL_W-1:0]         sel;
   logic [WB_DATA_WIDTH-1:0] dout;
   logic [WB_DATA_WIDTH-1:0] din;
   logic                     ack;
   logic                     err;
   logic                     rty;

   modport master (
      output cyc, stb, adr, we, sel, dout,
      input  din, ack, err, rty
   );

   modport slave (
      input  cyc, stb, adr, we, sel, dout,
      output din, ack, err, rty
   );

endinterface

// File: rtl/wb_byte_ram.sv
// Word array with per-byte write enables, registered read and synchronous clear.
module wb_byte_ram #(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned WB_DATA_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic                       rd_en,
   input  logic [$clog2(DEPTH)-1:0]   addr,
   input  logic [WB_DATA_WIDTH/8-1:0] sel,
   input  logic [WB_DATA_WIDTH-1:0]   wdata,
   output logic [WB_DATA_WIDTH-1:0]   rdata
);

   localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;

   logic [WB_DATA_WIDTH-1:0] mem [DEPTH];
   logic [WB_DATA_WIDTH-1:0] rdata_q;

   // Array update: whole-array clear on reset, otherwise byte-masked write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         for (int unsigned b = 0; b < SEL_W; b++) begin
            if (sel[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // Read register returns zero whenever no read is requested.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rd_en ? mem[addr] : '0;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic slave terminating each access with one ack/err/rty pulse,
// backed by a byte-writable word array.
module wb_mem_responder
   import wb_pkg_hdl::*;
#(
   parameter int unsigned              WB_ADDR_WIDTH = 32,
   parameter int unsigned              WB_DATA_WIDTH = 16,
   parameter int unsigned              DEPTH         = 16,
   parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter int unsigned              WAIT_CYCLES   = 0
) (
   input logic clk,
   input logic rst,
   input logic busy,
   wb_if.slave bus
);

   localparam int unsigned SEL_W   = WB_DATA_WIDTH / 8;
   localparam int unsigned BYTE_SH = $clog2(SEL_W);
   localparam int unsigned IDX_W   = $clog2(DEPTH);

   wb_resp_state_t           state_q;
   wb_resp_state_t           state_d;
   logic [WB_RESP_CNT_W-1:0] cnt_q;
   logic [WB_RESP_CNT_W-1:0] cnt_d;
   logic                     accept_c;

   logic [IDX_W-1:0]         idx_q;
   logic                     we_q;
   logic [SEL_W-1:0]         sel_q;
   logic [WB_DATA_WIDTH-1:0] dat_q;
   wb_resp_status_t          status_q;

   logic [WB_ADDR_WIDTH-1:0] off_c;
   logic [WB_ADDR_WIDTH-1:0] word_c;
   logic                     in_range_c;
   wb_resp_status_t          live_status_c;

   logic [IDX_W-1:0]         req_idx_c;
   logic                     req_we_c;
   logic [SEL_W-1:0]         req_sel_c;
   logic [WB_DATA_WIDTH-1:0] req_dat_c;
   wb_resp_status_t          req_status_c;

   logic                     wr_en_c;
   logic                     rd_en_c;
   logic                     ack_q;
   logic                     err_q;
   logic                     rty_q;
   logic [WB_DATA_WIDTH-1:0] rd_data;

   // Address decode; byte-offset bits drop out of the word index.
   assign off_c         = bus.adr - BASE_ADDR;
   assign word_c        = off_c >> BYTE_SH;
   assign in_range_c    = (bus.adr >= BASE_ADDR) && (word_c < WB_ADDR_WIDTH'(DEPTH));
   assign live_status_c = wb_resp_classify(busy, in_range_c);

   // Live bus fields while idle, captured fields once a transfer is accepted.
   always_comb begin
      req_idx_c    = idx_q;
      req_we_c     = we_q;
      req_sel_c    = sel_q;
      req_dat_c    = dat_q;
      req_status_c = status_q;
      if (state_q == WB_RESP_IDLE) begin
         req_idx_c    = word_c[IDX_W-1:0];
         req_we_c     = bus.we;
         req_sel_c    = bus.sel;
         req_dat_c    = bus.dout;
         req_status_c = live_status_c;
      end
   end

   // State and wait counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WB_RESP_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: accept, count wait states (abort when cyc drops), terminate once.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept_c = 1'b0;
      unique case (state_q)
         WB_RESP_IDLE: begin
            if (bus.cyc && bus.stb) begin
               accept_c = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d = WB_RESP_TERM;
               end else begin
                  state_d = WB_RESP_WAIT;
                  cnt_d   = WB_RESP_CNT_W'(WAIT_CYCLES - 1);
               end
            end
         end
         WB_RESP_WAIT: begin
            if (!bus.cyc) begin
               state_d = WB_RESP_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = WB_RESP_TERM;
            end else begin
               cnt_d = cnt_q - WB_RESP_CNT_W'(1);
            end
         end
         WB_RESP_TERM: begin
            state_d = WB_RESP_IDLE;
         end
         default: begin
            state_d = WB_RESP_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Capture the request at acceptance so later bus changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q    <= '0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         dat_q    <= '0;
         status_q <= WB_RESP_OK;
      end else if (accept_c) begin
         idx_q    <= req_idx_c;
         we_q     <= req_we_c;
         sel_q    <= req_sel_c;
         dat_q    <= req_dat_c;
         status_q <= req_status_c;
      end
   end

   // Writes commit on the edge entering TERM; reads launch from TERM so data
   // lines up with the registered termination pulse.
   assign wr_en_c = (state_d == WB_RESP_TERM) && (state_q != WB_RESP_TERM) &&
                    req_we_c && (req_status_c == WB_RESP_OK);
   assign rd_en_c = (state_q == WB_RESP_TERM) && !we_q && (status_q == WB_RESP_OK);

   // Termination pulse registers, one cycle per TERM visit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         rty_q <= 1'b0;
      end else begin
         ack_q <= (state_q == WB_RESP_TERM) && (status_q == WB_RESP_OK);
         err_q <= (state_q == WB_RESP_TERM) && (status_q == WB_RESP_ERR);
         rty_q <= (state_q == WB_RESP_TERM) && (status_q == WB_RESP_RTY);
      end
   end

   wb_byte_ram #(
      .DEPTH         (DEPTH),
      .WB_DATA_WIDTH (WB_DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en_c),
      .rd_en (rd_en_c),
      .addr  (req_idx_c),
      .sel   (req_sel_c),
      .wdata (req_dat_c),
      .rdata (rd_data)
   );

   assign bus.ack = ack_q;
   assign bus.err = err_q;
   assign bus.rty = rty_q;
   assign bus.din = rd_data;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: a zero-wait instance at base 0 and a three-wait
// instance at base 0x100 share one stimulus port, selected by use3.
module tb_wb_mem_responder;

   logic        clk;
   logic        rst;
   logic        cyc;
   logic        stb;
   logic        we;
   logic        busy;
   logic        use3;
   logic [31:0] adr;
   logic [1:0]  sel;
   logic [15:0] dout;
   logic [2:0]  obs_term;
   logic [15:0] obs_din;

   int checks = 0;
   int passed = 0;

   // Reference contents of each instance's word array.
   logic [15:0] mdl [2][16];
   logic [31:0] base_of [2] = '{32'h0, 32'h100};
   int          wait_of [2] = '{0, 3};

   wb_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16)) bus0 ();
   wb_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16)) bus3 ();

   assign bus0.cyc  = cyc & ~use3;
   assign bus0.stb  = stb & ~use3;
   assign bus0.adr  = adr;
   assign bus0.we   = we;
   assign bus0.sel  = sel;
   assign bus0.dout = dout;
   assign bus3.cyc  = cyc & use3;
   assign bus3.stb  = stb & use3;
   assign bus3.adr  = adr;
   assign bus3.we   = we;
   assign bus3.sel  = sel;
   assign bus3.dout = dout;

   assign obs_term = use3 ? {bus3.ack, bus3.err, bus3.rty} : {bus0.ack, bus0.err, bus0.rty};
   assign obs_din  = use3 ? bus3.din : bus0.din;

   wb_mem_responder #(
      .WB_ADDR_WIDTH (32), .WB_DATA_WIDTH (16), .DEPTH (16),
      .BASE_ADDR (32'h0), .WAIT_CYCLES (0)
   ) dut0 (.clk(clk), .rst(rst), .busy(busy), .bus(bus0));

   wb_mem_responder #(
      .WB_ADDR_WIDTH (32), .WB_DATA_WIDTH (16), .DEPTH (16),
      .BASE_ADDR (32'h100), .WAIT_CYCLES (3)
   ) dut3 (.clk(clk), .rst(rst), .busy(busy), .bus(bus3));

   always #5 clk = ~clk;

   function automatic void clear_model();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++) begin
            mdl[d][i] = 16'h0;
         end
      end
   endfunction

   // Reference: term encoded {ack,err,rty}; busy -> retry, bad address -> error.
   function automatic void ref_xfer(input int dsel, input logic [31:0] a, input logic w,
                                    input logic [1:0] s, input logic [15:0] d, input logic b,
                                    output logic [2:0] term, output logic [15:0] rd);
      int unsigned idx;
      rd = 16'h0;
      if (b) begin
         term = 3'b001;
      end else if (a < base_of[dsel] || ((a - base_of[dsel]) / 2) >= 16) begin
         term = 3'b010;
      end else begin
         term = 3'b100;
         idx  = (a - base_of[dsel]) / 2;
         if (w) begin
            for (int i = 0; i < 2; i++) begin
               if (s[i]) mdl[dsel][idx][8*i +: 8] = d[8*i +: 8];
            end
         end else begin
            rd = mdl[dsel][idx];
         end
      end
   endfunction

   // One transfer, master drops cyc/stb on seeing a termination; bus fields are
   // scrambled after acceptance. obs/exp = {term, din, latency, early, tail}.
   task automatic run_one(input int dsel, input logic [31:0] a, input logic w,
                          input logic [1:0] s, input logic [15:0] d, input logic b,
                          output logic [28:0] obs, output logic [28:0] exp);
      logic [2:0]  term;
      logic [15:0] rd;
      logic [2:0]  eterm;
      logic [15:0] erd;
      logic [7:0]  lat;
      logic        early;
      logic        tail;
      ref_xfer(dsel, a, w, s, d, b, eterm, erd);
      term = 3'b0; rd = 16'h0; lat = 8'h0; early = 1'b0;
      use3 = (dsel == 1);
      adr = a; we = w; sel = s; dout = d; busy = b; cyc = 1'b1; stb = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         adr = $urandom; dout = 16'($urandom); sel = 2'($urandom);
         busy = 1'($urandom); we = 1'($urandom);
         if (obs_term != 3'b0) begin
            term = obs_term; rd = obs_din; lat = 8'(k);
            break;
         end
         if (obs_din != 16'h0) early = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0; busy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tail = |{obs_term, obs_din};
      obs = {term, rd, lat, early, tail};
      exp = {eterm, erd, 8'(wait_of[dsel] + 2), 1'b0, 1'b0};
   endtask

   task automatic test_reset();
      logic [28:0] obs, exp;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; busy = 1'b0; use3 = 1'b0;
      adr = 32'h0; sel = 2'b0; dout = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus0.ack, bus0.err, bus0.rty, bus0.din, bus3.ack, bus3.err, bus3.rty, bus3.din} !== 38'h0)
         $display("FAIL reset_outputs got=%h want=0",
                  {bus0.ack, bus0.err, bus0.rty, bus0.din, bus3.ack, bus3.err, bus3.rty, bus3.din});
      else passed++;
      rst = 1'b0;
      clear_model();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++) begin
            run_one(d, base_of[d] + 32'(2 * i), 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) $display("FAIL reset_word d=%0d i=%0d got=%h want=%h", d, i, obs, exp);
            else passed++;
         end
      end
   endtask

   task automatic test_basic();
      logic [28:0] obs, exp;
      run_one(0, 32'h4, 1'b1, 2'b11, 16'hBEEF, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[28:26] !== 3'b100 || obs[9:2] !== 8'd2)
         $display("FAIL basic_write got=%h want=%h", obs, exp);
      else passed++;
      run_one(0, 32'h4, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[25:10] !== 16'hBEEF)
         $display("FAIL basic_read got=%h want=%h", obs, exp);
      else passed++;
   endtask

   task automatic test_byte_enables();
      logic [28:0] obs, exp;
      run_one(0, 32'h4, 1'b1, 2'b01, 16'h12AB, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) $display("FAIL be_write_low got=%h want=%h", obs, exp); else passed++;
      run_one(0, 32'h5, 1'b0, 2'b00, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[25:10] !== 16'hBEAB)
         $display("FAIL be_read_low got=%h want=%h", obs, exp);
      else passed++;
      run_one(0, 32'h4, 1'b1, 2'b00, 16'h7777, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[28:26] !== 3'b100)
         $display("FAIL be_write_none got=%h want=%h", obs, exp);
      else passed++;
      run_one(0, 32'h4, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[25:10] !== 16'hBEAB)
         $display("FAIL be_read_none got=%h want=%h", obs, exp);
      else passed++;
   endtask

   task automatic test_out_of_range();
      logic [28:0] obs, exp;
      run_one(0, 32'h20, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[28:26] !== 3'b010 || obs[25:10] !== 16'h0)
         $display("FAIL oor_read got=%h want=%h", obs, exp);
      else passed++;
      run_one(0, 32'h20, 1'b1, 2'b11, 16'hDEAD, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) $display("FAIL oor_write got=%h want=%h", obs, exp); else passed++;
      run_one(0, 32'h0, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[25:10] !== 16'h0)
         $display("FAIL oor_alias_word0 got=%h want=%h", obs, exp);
      else passed++;
      run_one(1, 32'hF0, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[28:26] !== 3'b010)
         $display("FAIL oor_below_base got=%h want=%h", obs, exp);
      else passed++;
   endtask

   task automatic test_retry();
      logic [28:0] obs, exp;
      run_one(0, 32'h6, 1'b1, 2'b11, 16'h5555, 1'b1, obs, exp);
      checks++;
      if (obs !== exp || obs[28:26] !== 3'b001)
         $display("FAIL retry_busy got=%h want=%h", obs, exp);
      else passed++;
      run_one(0, 32'h6, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[25:10] !== 16'h0)
         $display("FAIL retry_unchanged got=%h want=%h", obs, exp);
      else passed++;
      run_one(0, 32'h6, 1'b1, 2'b11, 16'h5555, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) $display("FAIL retry_again got=%h want=%h", obs, exp); else passed++;
      run_one(0, 32'h6, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[25:10] !== 16'h5555)
         $display("FAIL retry_read got=%h want=%h", obs, exp);
      else passed++;
   endtask

   task automatic test_wait_states();
      logic [28:0] obs, exp;
      int          hits;
      run_one(1, 32'h104, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[9:2] !== 8'd5)
         $display("FAIL wait_latency got=%h want=%h", obs, exp);
      else passed++;
      // Abort: accepted at edge N, cyc seen low at N+2.
      use3 = 1'b1; adr = 32'h10A; we = 1'b1; sel = 2'b11; dout = 16'hC3C3;
      cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      hits = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (obs_term != 3'b0 || obs_din != 16'h0) hits++;
      end
      checks++;
      if (hits !== 0) $display("FAIL wait_abort_quiet got=%0d want=0", hits); else passed++;
      run_one(1, 32'h10A, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[25:10] !== 16'h0)
         $display("FAIL wait_abort_nowrite got=%h want=%h", obs, exp);
      else passed++;
      run_one(1, 32'h10A, 1'b1, 2'b11, 16'h3C5A, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) $display("FAIL wait_after_abort got=%h want=%h", obs, exp); else passed++;
      run_one(1, 32'h10B, 1'b0, 2'b10, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[25:10] !== 16'h3C5A)
         $display("FAIL wait_readback got=%h want=%h", obs, exp);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] pat;
      logic [15:0] exp_pat;
      logic [2:0]  t;
      logic [15:0] expd;
      logic        other;
      logic        din_bad;
      int          w;
      for (int d = 0; d < 2; d++) begin
         w = wait_of[d];
         ref_xfer(d, base_of[d] + 32'h4, 1'b0, 2'b11, 16'h0, 1'b0, t, expd);
         exp_pat = (16'h1 << (w + 2)) | (16'h1 << (2 * w + 4));
         pat = 16'h0; other = 1'b0; din_bad = 1'b0;
         use3 = (d == 1); adr = base_of[d] + 32'h4; we = 1'b0; sel = 2'b11; busy = 1'b0;
         cyc = 1'b1; stb = 1'b1;
         for (int k = 1; k <= 2 * w + 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            pat[k] = obs_term[2];
            other  = other | (|obs_term[1:0]);
            if (obs_term[2] ? (obs_din !== expd) : (obs_din !== 16'h0)) din_bad = 1'b1;
            if (k == 2 * w + 4) begin
               cyc = 1'b0; stb = 1'b0;
            end
         end
         checks++;
         if ({pat, other, din_bad} !== {exp_pat, 2'b00})
            $display("FAIL back_to_back d=%0d got=%h want=%h", d, {pat, other, din_bad}, {exp_pat, 2'b00});
         else passed++;
      end
   endtask

   task automatic test_random();
      logic [28:0] obs, exp;
      logic [31:0] a;
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
               0, 1:    a = base_of[d] + 32'($urandom_range(0, 31));
               2:       a = base_of[d] + 32'($urandom_range(32, 80));
               default: a = (d == 1) ? 32'($urandom_range(0, 255)) : $urandom;
            endcase
            run_one(d, a, 1'($urandom), 2'($urandom), 16'($urandom),
                    ($urandom_range(0, 7) == 0), obs, exp);
            checks++;
            if (obs !== exp)
               $display("FAIL random d=%0d n=%0d adr=%h got=%h want=%h", d, n, a, obs, exp);
            else passed++;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [28:0] obs, exp;
      int          hits;
      use3 = 1'b1; adr = 32'h10C; we = 1'b1; sel = 2'b11; dout = 16'hA5A5; busy = 1'b0;
      cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus0.ack, bus0.err, bus0.rty, bus0.din, bus3.ack, bus3.err, bus3.rty, bus3.din} !== 38'h0)
         $display("FAIL rst_mid_outputs got=%h want=0",
                  {bus0.ack, bus0.err, bus0.rty, bus0.din, bus3.ack, bus3.err, bus3.rty, bus3.din});
      else passed++;
      rst = 1'b0;
      clear_model();
      hits = 0;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         if (obs_term != 3'b0) hits++;
      end
      checks++;
      if (hits !== 0) $display("FAIL rst_mid_late_term got=%0d want=0", hits); else passed++;
      run_one(1, 32'h10C, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[25:10] !== 16'h0)
         $display("FAIL rst_mid_nowrite got=%h want=%h", obs, exp);
      else passed++;
      run_one(0, 32'h4, 1'b0, 2'b11, 16'h0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp || obs[25:10] !== 16'h0)
         $display("FAIL rst_mid_cleared got=%h want=%h", obs, exp);
      else passed++;
   endtask

   initial begin
      clk = 1'b0;
      test_reset();
      test_basic();
      test_byte_enables();
      test_out_of_range();
      test_retry();
      test_wait_states();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
